conv_arbiter: RTL and testbench
===============================

CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 The block SHALL use one clock, clock, with all state changing on its rising edge; reset is synchronous and active-low, reset_, sampled only at that edge.
REQ-002 clock  input  1  system clock.
REQ-003 reset_  input  1  synchronous active-low reset.
REQ-004 soc0, soc1  input  1 each  start-of-conversion request from client 0 / client 1.
REQ-005 eoc0, eoc1  output  1 each  end-of-conversion to client 0 / 1; 0 = conversion in progress.
REQ-006 x0, x1  output  8 each  converted byte returned to client 0 / 1.
REQ-007 soc  output  1  start-of-conversion to the shared converter.
REQ-008 eoc  input  1  end-of-conversion from the shared converter.
REQ-009 x  input  8  converter data, valid while eoc=1 after a conversion.

Function
REQ-010 The block SHALL share one soc/eoc converter between two clients; each client sees an independent soc/eoc/x converter.
REQ-011 Client n SHALL request when socn=1 and eocn=1.
REQ-012 FSM states SHALL be IDLE, START and WAIT.
REQ-013 IDLE: with one request pending, grant that client; with both pending, grant the client not in LAST (round-robin); with none, stay in IDLE.
REQ-014 On a grant edge: soc<=1, eocn<=0 for the granted client, GNT<=n, LAST<=n, next state START.
REQ-015 START: hold soc=1 until eoc=0 is sampled, then soc<=0, next state WAIT.
REQ-016 WAIT: leave only when eoc=1 and socGNT=0 are sampled on the same edge.
REQ-017 On WAIT exit: xGNT<=x, eocGNT<=1, next state IDLE.
REQ-018 If eoc=1 but socGNT is still 1, WAIT SHALL persist; x is sampled on the exit edge, not earlier.
REQ-019 The non-granted client's eoc and x SHALL remain unchanged for the whole transaction; its request stays pending.
REQ-020 Minimum latency from grant edge to eocn=1 SHALL be 2 edges (START then WAIT exit); there is no upper bound and no timeout.
REQ-021 A new grant SHALL be possible on the edge immediately after WAIT exit; back-to-back requests from both clients alternate 0,1,0,1.
REQ-022 A request raised on the same edge that completes the other client SHALL be granted on the following edge.
REQ-023 eoc=0 seen in IDLE or WAIT, and socn toggles by the granted client in START, SHALL be ignored.

Reset
REQ-024 When reset_=0 at an edge: state<=IDLE, soc<=0, eoc0<=1, eoc1<=1, x0<=8'h00, x1<=8'h00, LAST<=1 (client 0 wins the first tie), GNT<=0.
REQ-025 Reset mid-transaction SHALL abort it: soc drops to 0 on that edge and the converter result is discarded.
REQ-026 All outputs SHALL be driven directly from registers.

Structure
REQ-027 Package conv_arbiter_pkg SHALL hold the state encodings (IDLE=0, START=1, WAIT=2), data width 8 and client count 2.
REQ-028 The round-robin choice SHALL be a combinational sub-module rr_pick: inputs req[1:0] and last, outputs valid and gnt.
REQ-029 Control SHALL be a single FSM; datapath registers are x0, x1, GNT and LAST.

Verification
REQ-030 Reset then soc0=1 only; the converter pulls eoc low 1 cycle after soc and returns eoc=1, x=8'hA5 3 cycles later; client drops soc0 after eoc0=0 -> soc high 1 cycle, eoc0=1 with x0=8'hA5, x1=8'h00, eoc1=1 throughout.
REQ-031 soc0=soc1=1 on the same edge after reset -> client 0 is served first (x0=8'h11), then client 1 (x1=8'h22); a further simultaneous pair is served 0 then 1 again.
REQ-032 Client 1 holds soc1=1 until 2 cycles after the converter's eoc=1 -> eoc1 stays 0 until the edge after soc1=0; x1 equals the x on that edge (change x from 8'h33 to 8'h44 meanwhile -> 8'h44).
REQ-033 reset_=0 for one edge during WAIT -> next cycle soc=0, eoc0=eoc1=1, x0=x1=8'h00, state IDLE; the next request proceeds normally.
REQ-034 Client 1 requests while client 0 is in WAIT -> eoc1 stays 1 and x1 is unchanged until client 0 completes; client 1 is granted on the next edge.

Source files
------------

// File: rtl/conv_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-client converter arbiter.
package conv_arbiter_pkg;
  localparam int DATA_W      = 8;
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/conv_arbiter_if.sv
// Client-side and converter-side soc/eoc/x signals of the arbiter.
interface conv_arbiter_if;
  import conv_arbiter_pkg::*;

  logic              soc0;
  logic              soc1;
  logic              eoc0;
  logic              eoc1;
  logic [DATA_W-1:0] x0;
  logic [DATA_W-1:0] x1;
  logic              soc;
  logic              eoc;
  logic [DATA_W-1:0] x;

  // Arbiter view.
  modport slave (
    input  soc0, soc1, eoc, x,
    output eoc0, eoc1, x0, x1, soc
  );

  // Environment view: clients plus the shared converter.
  modport master (
    output soc0, soc1, eoc, x,
    input  eoc0, eoc1, x0, x1, soc
  );
endinterface

// File: rtl/conv_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the client that was not served last wins.
module rr_pick
  import conv_arbiter_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   last,
  output logic                   valid,
  output logic                   gnt
);
  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    if (&req) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end
endmodule

// File: rtl/conv_arbiter.sv
// Shares one soc/eoc converter between two clients, each of which sees its own converter.
module conv_arbiter
  import conv_arbiter_pkg::*;
(
  input  logic           clock,
  input  logic           reset_,
  conv_arbiter_if.slave  bus
);
  state_t                 state_q;
  logic                   soc_q;
  logic [NUM_CLIENTS-1:0] eoc_q;
  logic [DATA_W-1:0]      x_q [NUM_CLIENTS];
  logic                   gnt_q;
  logic                   last_q;

  logic [NUM_CLIENTS-1:0] soc_in;
  logic [NUM_CLIENTS-1:0] req;
  logic                   pick_valid;
  logic                   pick_gnt;

  assign soc_in = {bus.soc1, bus.soc0};

  // A client may only request while it is not already being served.
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_req
    assign req[gi] = soc_in[gi] & eoc_q[gi];
  end

  rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= IDLE;
      soc_q   <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        eoc_q[i] <= 1'b1;
        x_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            soc_q           <= 1'b1;
            eoc_q[pick_gnt] <= 1'b0;
            gnt_q           <= pick_gnt;
            last_q          <= pick_gnt;
            state_q         <= START;
          end
        end
        START: begin
          if (!bus.eoc) begin
            soc_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Result is handed over only once the client has released its soc.
          if (bus.eoc && !soc_in[gnt_q]) begin
            x_q[gnt_q]   <= bus.x;
            eoc_q[gnt_q] <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.soc  = soc_q;
  assign bus.eoc0 = eoc_q[0];
  assign bus.eoc1 = eoc_q[1];
  assign bus.x0   = x_q[0];
  assign bus.x1   = x_q[1];
endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter: each task drives one scenario and checks outputs inline.
module tb_conv_arbiter;
  logic clock;
  logic reset_;
  int   vectors;
  int   miscompares;

  conv_arbiter_if bus ();

  conv_arbiter dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s0, input logic s1, input logic e, input logic [7:0] xv);
    bus.soc0 = s0;
    bus.soc1 = s1;
    bus.eoc  = e;
    bus.x    = xv;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hEE);
    tick();
    do_reset();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b011) begin
      miscompares++;
      $display("FAIL reset_ctrl: soc/eoc0/eoc1=%b expected 011", {bus.soc, bus.eoc0, bus.eoc1});
    end
    vectors++;
    if ({bus.x0, bus.x1} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: x0=%h x1=%h expected 00 00", bus.x0, bus.x1);
    end
    // eoc=0 in IDLE with nobody requesting must not start anything
    drive(1'b0, 1'b0, 1'b0, 8'h12);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b011) begin
      miscompares++;
      $display("FAIL idle_eoc_low: soc/eoc0/eoc1=%b expected 011", {bus.soc, bus.eoc0, bus.eoc1});
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b101) begin
      miscompares++;
      $display("FAIL single_grant: soc/eoc0/eoc1=%b expected 101", {bus.soc, bus.eoc0, bus.eoc1});
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b001) begin
      miscompares++;
      $display("FAIL single_start_exit: soc/eoc0/eoc1=%b expected 001", {bus.soc, bus.eoc0, bus.eoc1});
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hA5);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1, bus.x0, bus.x1} !== {3'b011, 8'hA5, 8'h00}) begin
      miscompares++;
      $display("FAIL single_done: soc/eoc0/eoc1=%b x0=%h x1=%h expected 011 a5 00",
               {bus.soc, bus.eoc0, bus.eoc1}, bus.x0, bus.x1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h5A);
    tick();
    vectors++;
    if (bus.x0 !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_hold: x0=%h expected a5", bus.x0);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] xa [2];
    xa[0] = 8'h11;
    xa[1] = 8'h22;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h00);
      tick();
      vectors++;
      if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b101) begin
        miscompares++;
        $display("FAIL tie_grant0 pass%0d: soc/eoc0/eoc1=%b expected 101", pass, {bus.soc, bus.eoc0, bus.eoc1});
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b1, 1'b1, xa[0]);
      tick();
      vectors++;
      if ({bus.eoc0, bus.eoc1, bus.x0} !== {2'b11, xa[0]}) begin
        miscompares++;
        $display("FAIL tie_done0 pass%0d: eoc0/eoc1=%b x0=%h expected 11 %h", pass, {bus.eoc0, bus.eoc1}, bus.x0, xa[0]);
      end
      tick();
      vectors++;
      if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b110) begin
        miscompares++;
        $display("FAIL tie_grant1 pass%0d: soc/eoc0/eoc1=%b expected 110", pass, {bus.soc, bus.eoc0, bus.eoc1});
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b0, 1'b1, xa[1]);
      tick();
      vectors++;
      if ({bus.eoc0, bus.eoc1, bus.x0, bus.x1} !== {2'b11, xa[0], xa[1]}) begin
        miscompares++;
        $display("FAIL tie_done1 pass%0d: eoc0/eoc1=%b x0=%h x1=%h expected 11 %h %h",
                 pass, {bus.eoc0, bus.eoc1}, bus.x0, bus.x1, xa[0], xa[1]);
      end
      xa[0] = 8'h55;
      xa[1] = 8'h66;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_start_hold();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    // client toggles soc0 and converter keeps eoc=1: START must hold soc
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_hold_a: soc/eoc0=%b expected 10", {bus.soc, bus.eoc0});
    end
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0} !== 2'b10) begin
      miscompares++;
      $display("FAIL start_hold_b: soc/eoc0=%b expected 10", {bus.soc, bus.eoc0});
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0} !== 2'b00) begin
      miscompares++;
      $display("FAIL start_leave: soc/eoc0=%b expected 00", {bus.soc, bus.eoc0});
    end
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    tick();
    vectors++;
    if ({bus.eoc0, bus.x0} !== {1'b1, 8'h77}) begin
      miscompares++;
      $display("FAIL start_done: eoc0=%b x0=%h expected 1 77", bus.eoc0, bus.x0);
    end
    $display("test_start_hold done");
  endtask

  task automatic test_late_release();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b110) begin
      miscompares++;
      $display("FAIL late_grant1: soc/eoc0/eoc1=%b expected 110", {bus.soc, bus.eoc0, bus.eoc1});
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'h33);
    tick();
    vectors++;
    if ({bus.eoc1, bus.x1} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL late_wait_a: eoc1=%b x1=%h expected 0 00", bus.eoc1, bus.x1);
    end
    tick();
    vectors++;
    if ({bus.eoc1, bus.x1} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL late_wait_b: eoc1=%b x1=%h expected 0 00", bus.eoc1, bus.x1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h44);
    tick();
    vectors++;
    if ({bus.eoc1, bus.x1, bus.eoc0} !== {1'b1, 8'h44, 1'b1}) begin
      miscompares++;
      $display("FAIL late_done: eoc1=%b x1=%h eoc0=%b expected 1 44 1", bus.eoc1, bus.x1, bus.eoc0);
    end
    $display("test_late_release done");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1, bus.x0, bus.x1} !== {3'b011, 16'h0000}) begin
      miscompares++;
      $display("FAIL abort_state: soc/eoc0/eoc1=%b x0=%h x1=%h expected 011 00 00",
               {bus.soc, bus.eoc0, bus.eoc1}, bus.x0, bus.x1);
    end
    drive(1'b0, 1'b0, 1'b1, 8'h99);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.x0} !== {2'b01, 8'h00}) begin
      miscompares++;
      $display("FAIL abort_discard: soc/eoc0=%b x0=%h expected 01 00", {bus.soc, bus.eoc0}, bus.x0);
    end
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hBB);
    tick();
    vectors++;
    if ({bus.eoc1, bus.x1, bus.x0} !== {1'b1, 8'hBB, 8'h00}) begin
      miscompares++;
      $display("FAIL abort_recover: eoc1=%b x1=%h x0=%h expected 1 bb 00", bus.eoc1, bus.x1, bus.x0);
    end
    $display("test_reset_in_wait done");
  endtask

  task automatic test_pending_other();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({bus.soc, bus.eoc0, bus.eoc1, bus.x1} !== {3'b001, 8'h00}) begin
        miscompares++;
        $display("FAIL pend_wait%0d: soc/eoc0/eoc1=%b x1=%h expected 001 00",
                 i, {bus.soc, bus.eoc0, bus.eoc1}, bus.x1);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 8'hC3);
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1, bus.x0, bus.x1} !== {3'b011, 8'hC3, 8'h00}) begin
      miscompares++;
      $display("FAIL pend_done0: soc/eoc0/eoc1=%b x0=%h x1=%h expected 011 c3 00",
               {bus.soc, bus.eoc0, bus.eoc1}, bus.x0, bus.x1);
    end
    tick();
    vectors++;
    if ({bus.soc, bus.eoc0, bus.eoc1} !== 3'b110) begin
      miscompares++;
      $display("FAIL pend_grant1: soc/eoc0/eoc1=%b expected 110", {bus.soc, bus.eoc0, bus.eoc1});
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h3C);
    tick();
    vectors++;
    if ({bus.eoc1, bus.x1, bus.x0} !== {1'b1, 8'h3C, 8'hC3}) begin
      miscompares++;
      $display("FAIL pend_done1: eoc1=%b x1=%h x0=%h expected 1 3c c3", bus.eoc1, bus.x1, bus.x0);
    end
    $display("test_pending_other done");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_      = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    test_reset();
    test_single();
    test_back_to_back();
    test_start_hold();
    test_late_release();
    test_reset_in_wait();
    test_pending_other();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
